// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared constants, clear FSM encoding and default geometry for regfile_mp
package regfile_mp_pkg;
    localparam logic HIGH     = 1'b1;
    localparam logic LOW      = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DATA_D = 32;
    localparam int DEF_ADDR_W = 5;
    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
endpackage

// File: rtl/regfile_mp.sv
// regfile_mp: two combinational read ports with same-cycle write bypass, one write port,
// and a sequenced runtime clear that zeroes one entry per cycle.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DATA_D  = DEF_DATA_D,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic [DATA_W-1:0] rd0_data,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    input  logic              we_,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done
);
    localparam logic [ADDR_W:0]   DEPTH = (ADDR_W + 1)'(DATA_D);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DATA_D - 1);

    logic [DATA_W-1:0] r_mem [DATA_D];
    logic [ADDR_W-1:0] r_ptr;
    state_t            r_state;
    state_t            w_next;
    logic              w_wr;

    // An address is usable when it is in range and not the hardwired zero entry.
    function automatic logic f_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH) && !(ZERO_R0 && a == '0);
    endfunction

    assign w_wr     = (we_ == ENABLE_) && (r_state == IDLE) && f_ok(wr_addr);
    assign rd0_data = !f_ok(rd0_addr) ? '0 : (w_wr && rd0_addr == wr_addr) ? wr_data : r_mem[rd0_addr];
    assign rd1_data = !f_ok(rd1_addr) ? '0 : (w_wr && rd1_addr == wr_addr) ? wr_data : r_mem[rd1_addr];
    assign busy     = (r_state == CLEAR) ? HIGH : LOW;
    assign clr_done = (r_state == CLEAR && r_ptr == LAST) ? HIGH : LOW;

    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? (clr_req ? CLEAR : IDLE) : ((r_ptr == LAST) ? IDLE : CLEAR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_ptr <= '0;
        else r_ptr <= (r_state == CLEAR && r_ptr != LAST) ? r_ptr + 1'b1 : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DATA_D; i++) r_mem[i] <= '0;
        end else if (r_state == CLEAR) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr) begin
            r_mem[wr_addr] <= wr_data;
        end
    end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, width of one register entry.
REQ-002 Parameter DATA_D, default 32, number of entries, 2..256.
REQ-003 Parameter ADDR_W, default 5, address width; DATA_D <= 2**ADDR_W.
REQ-004 Parameter ZERO_R0, default 0, 1 = entry 0 always reads zero and ignores writes.
REQ-005 Clock and reset are fixed: one clock, reset is asynchronous and active-high.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 rd0_addr  input  ADDR_W  read port 0 address.
REQ-009 rd0_data  output  DATA_W  read port 0 data, combinational.
REQ-010 rd1_addr  input  ADDR_W  read port 1 address.
REQ-011 rd1_data  output  DATA_W  read port 1 data, combinational.
REQ-012 we_  input  1  write enable, active-low.
REQ-013 wr_addr  input  ADDR_W  write address.
REQ-014 wr_data  input  DATA_W  write data.
REQ-015 clr_req  input  1  one-cycle request to start a runtime clear of all entries.
REQ-016 busy  output  1  high while a clear sequence runs.
REQ-017 clr_done  output  1  one-cycle pulse on the last clear cycle.

Function
REQ-018 Write: we_ low and busy low at a rising edge -> entry wr_addr <= wr_data; takes effect the same edge.
REQ-019 Read: rdN_data = entry rdN_addr, combinational, no cycle of latency.
REQ-020 Bypass: we_ low, busy low, rdN_addr == wr_addr -> rdN_data = wr_data in the same cycle; both ports bypass independently.
REQ-021 ZERO_R0=1: rdN_addr == 0 -> rdN_data = 0 with no bypass; writes to entry 0 are dropped.
REQ-022 Out-of-range address (>= DATA_D): read returns 0, write dropped, no other state change.
REQ-023 Clear FSM states: IDLE, CLEAR. IDLE --clr_req--> CLEAR, pointer = 0; in CLEAR zero entry[pointer] each cycle, pointer+1; pointer == DATA_D-1 -> clr_done=1, back to IDLE.
REQ-024 A clear takes exactly DATA_D cycles; busy is high in all of them.
REQ-025 While busy, we_ is ignored (write lost, no error), and clr_req is ignored.
REQ-026 While busy, reads return current array contents: cleared entries read 0, others keep their old value.
REQ-027 Same-edge clr_req and write in IDLE: the write is done first; then the clear starts at the next edge and overwrites it.
REQ-028 The pointer is ADDR_W wide and never exceeds DATA_D-1.

Reset
REQ-029 Reset asserted -> every entry = 0, FSM = IDLE, pointer = 0, busy = 0, clr_done = 0, with no clock needed.
REQ-030 Reset during CLEAR stops the sequence immediately; no clr_done pulse is produced.
REQ-031 First write is accepted at the first rising edge after reset deasserts.

Structure
REQ-032 Shared package/header holds HIGH/LOW, ENABLE_/DISABLE_, FSM state encodings and default DATA_W/DATA_D/ADDR_W.
REQ-033 Single module with a flop array; the clear FSM is inline. No sub-module.

Verification
REQ-034 Reset, then read all addresses on both ports -> all 0; busy=0, clr_done=0.
REQ-035 Write i to entry i for all i, then read port0=i and port1=DATA_D-1-i -> values i and DATA_D-1-i.
REQ-036 Write 0xA5A5A5A5 to addr 3 while rd0_addr=3 and rd1_addr=3 in the same cycle -> both read 0xA5A5A5A5 before the edge.
REQ-037 ZERO_R0=1: write 0xFFFFFFFF to addr 0 -> reads return 0; with ZERO_R0=0 -> reads return 0xFFFFFFFF.
REQ-038 Fill all entries, pulse clr_req -> busy high for exactly DATA_D cycles, clr_done pulse on the last, all entries 0; writes during busy are lost.
REQ-039 Assert reset at clear cycle 5 -> all entries 0, busy 0 at once, no clr_done; a normal write right after release succeeds.
